// File: rtl/uart_tx_sched.sv
// Transmit scheduler between the UART TX FIFO and the serializer: pops one byte at a time,
// issues a one-cycle start, tracks completion, gap and ack timeout. Define UART_TX_SCHED_CTS_EN for CTS gating.
module uart_tx_sched #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned GAP_CYCLES  = 0,
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_dout,
  output logic                   fifo_rd_en,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [DATA_WIDTH-1:0]  tx_data,
  input  logic                   cts_n,
  output logic                   sched_busy,
  output logic [COUNT_WIDTH-1:0] byte_count,
  output logic                   tx_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_ACK    = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_GAP    = 3'd6;

  // One shared counter serves both the ack timeout and the inter-byte gap.
  localparam int unsigned ACK_LAST = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int unsigned CNT_MAX  = (ACK_LAST > GAP_LAST) ? ACK_LAST : GAP_LAST;
  localparam int unsigned CNT_W    = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] ACK_LAST_C = CNT_W'(ACK_LAST);
  localparam logic [CNT_W-1:0] GAP_LAST_C = CNT_W'(GAP_LAST);

  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic [COUNT_WIDTH-1:0] byte_count_q, byte_count_d;
  logic                   tx_err_q, tx_err_d;
  logic                   cts_ok;

`ifdef UART_TX_SCHED_CTS_EN
  logic cts_meta_q, cts_meta_d;
  logic cts_sync_q, cts_sync_d;

  always_comb begin
    cts_meta_d = cts_n;
    cts_sync_d = cts_meta_q;
  end

  // Synchronizer resets to "not clear to send" so nothing starts until cts_n is seen low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      cts_meta_q <= cts_meta_d;
      cts_sync_q <= cts_sync_d;
    end
  end

  assign cts_ok = ~cts_sync_q;
`else
  logic unused_cts_n;
  assign unused_cts_n = cts_n;
  assign cts_ok       = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tx_data_d    = tx_data_q;
    byte_count_d = byte_count_q;
    tx_err_d     = tx_err_q;
    case (state_q)
      S_IDLE: begin
        if (enable && !fifo_empty && cts_ok) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        tx_data_d = fifo_dout;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        if (!tx_busy) state_d = S_START;
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_ACK;
      end
      S_ACK: begin
        // Busy takes priority so an ack on the last allowed cycle still counts.
        if (tx_busy) begin
          state_d = S_DONE;
        end else if (cnt_q == ACK_LAST_C) begin
          tx_err_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (!tx_busy) begin
          byte_count_d = byte_count_q + COUNT_WIDTH'(1);
          cnt_d        = '0;
          state_d      = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST_C) state_d = S_IDLE;
        else                     cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tx_data_q    <= '0;
      byte_count_q <= '0;
      tx_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tx_data_q    <= tx_data_d;
      byte_count_q <= byte_count_d;
      tx_err_q     <= tx_err_d;
    end
  end

  assign fifo_rd_en = (state_q == S_SETTLE);
  assign tx_start   = (state_q == S_START);
  assign sched_busy = (state_q != S_IDLE);
  assign tx_data    = tx_data_q;
  assign byte_count = byte_count_q;
  assign tx_err     = tx_err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: bench-side FIFO and transmitter models plus a
// per-byte timeline model of the scheduler, directed scenarios followed by random traffic.
`timescale 1ns/1ps
module tb_uart_tx_sched;
  localparam int unsigned DW    = 8;
  localparam int unsigned GAP   = 4;
  localparam int unsigned TMO   = 15;
  localparam int unsigned CW    = 4;
  localparam int          NEVER = 1000;

  logic          clk = 1'b0;
  logic          reset, enable, fifo_empty, tx_busy, cts_n;
  logic [DW-1:0] fifo_dout, tx_data;
  logic          fifo_rd_en, tx_start, sched_busy, tx_err;
  logic [CW-1:0] byte_count;

  uart_tx_sched #(.DATA_WIDTH(DW), .GAP_CYCLES(GAP), .ACK_TIMEOUT(TMO), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .cts_n(cts_n), .sched_busy(sched_busy), .byte_count(byte_count), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, cyc = 0;
  // stimulus knobs, applied inside step() so they land in a well-defined cycle
  logic [DW-1:0] push_q[$];
  int            plan_a[$], plan_l[$];
  bit            en_knob = 0, cts_knob = 0, rst_req = 0, rand_push = 0;
  // bench FIFO and transmitter
  logic [DW-1:0] fifo_q[$];
  bit            pop_pend = 0, tx_have = 0;
  int            tx_s = 0, tx_a = 0, tx_l = 0;
  // timeline model of the byte in flight
  bit            m_fly = 0, m_err = 0;
  int            m_r = 0, m_last = 0, m_cnt_at = -1, m_err_at = -1;
  logic [DW-1:0] m_byte = '0, m_data = '0;
  logic [CW-1:0] m_count = '0;
  bit            h1 = 1, h2 = 1;
  // event logs for the directed literal checks
  int            rd_log[$], st_log[$];
  logic [DW-1:0] data_log[$];
  int            err_rise = -1, push_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
  endtask

  task automatic step();
    int a, l, k, s;
    bit cts_ok_m;
    @(negedge clk);
    cyc++;
    if (m_fly) begin
      if (cyc == m_r + 1)    m_data  = m_byte;
      if (cyc == m_cnt_at)   m_count = m_count + 1'b1;
      if (cyc == m_err_at)   m_err   = 1'b1;
      if (cyc == m_last + 1) m_fly   = 0;
    end
    check("fifo_rd_en", fifo_rd_en, m_fly && cyc == m_r);
    check("tx_start",   tx_start,   m_fly && cyc == m_r + 2);
    check("sched_busy", sched_busy, m_fly && cyc >= m_r && cyc <= m_last);
    check("tx_data",    tx_data,    m_data);
    check("byte_count", byte_count, m_count);
    check("tx_err",     tx_err,     m_err);
    if (fifo_rd_en) rd_log.push_back(cyc);
    if (tx_start) begin
      st_log.push_back(cyc);
      data_log.push_back(tx_data);
      tx_have = 1;
      tx_s    = cyc;
    end
    if (tx_err && err_rise < 0) err_rise = cyc;
    // drive inputs for this cycle
    if (!reset) reset = 1'b1;
    if (pop_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
    pop_pend = fifo_rd_en;
    while (push_q.size() > 0) begin
      fifo_q.push_back(push_q.pop_front());
      push_cyc = cyc;
    end
    if (rand_push && fifo_q.size() < 8 && $urandom_range(0, 99) < 20) fifo_q.push_back(DW'($urandom));
    fifo_empty = (fifo_q.size() == 0);
    fifo_dout  = fifo_empty ? '0 : fifo_q[0];
    enable     = en_knob;
    cts_n      = cts_knob;
    tx_busy    = tx_have && (tx_a != NEVER) && (cyc >= tx_s + 1 + tx_a) && (cyc <= tx_s + tx_a + tx_l);
    if (rst_req) begin
      rst_req  = 0;
      reset    = 1'b0;
      m_fly    = 0;
      m_count  = '0;
      m_err    = 0;
      m_data   = '0;
      tx_have  = 0;
      tx_busy  = 1'b0;
      pop_pend = 0;
      h1 = 1;
      h2 = 1;
    end else begin
`ifdef UART_TX_SCHED_CTS_EN
      cts_ok_m = !h2;
`else
      cts_ok_m = 1;
`endif
      if (!m_fly && enable && !fifo_empty && cts_ok_m) begin
        if (plan_a.size() > 0) begin
          a = plan_a.pop_front();
          l = plan_l.pop_front();
        end else begin
          k = $urandom_range(0, 9);
          a = (k == 0) ? NEVER : (k == 1) ? int'(TMO) - 1 : (k <= 5) ? 0 : (k <= 7) ? 1 : int'($urandom_range(2, 5));
          l = $urandom_range(1, 6);
        end
        m_fly   = 1;
        m_r     = cyc + 1;
        m_byte  = fifo_q[0];
        tx_a    = a;
        tx_l    = l;
        tx_have = 0;
        s       = m_r + 2;
        if (a == NEVER) begin
          m_last   = s + int'(TMO);
          m_err_at = s + int'(TMO) + 1;
          m_cnt_at = -1;
        end else begin
          m_cnt_at = s + 2 + a + l;
          m_last   = s + 1 + a + l + int'(GAP);
          m_err_at = -1;
        end
      end
      h2 = h1;
      h1 = cts_n;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic step_until_rd(input int want, input int limit, input string name);
    int i;
    i = 0;
    while (rd_log.size() < want && i < limit) begin
      step();
      i++;
    end
    check(name, rd_log.size(), want);
  endtask

  task automatic clear_logs();
    rd_log.delete();
    st_log.delete();
    data_log.delete();
    err_rise = -1;
  endtask

  initial begin
    logic [DW-1:0] b0, b1, b2;
    reset = 1'b0; enable = 1'b0; fifo_empty = 1'b1; fifo_dout = '0; tx_busy = 1'b0; cts_n = 1'b0;
    run(2);
    en_knob = 1;
    run(2);

    // two bytes, long busy, pins latency and spacing
    clear_logs();
    plan_a = {0, 0}; plan_l = {10, 10};
    push_q = {8'hA5, 8'h3C};
    run(60);
    check("t1_pops", rd_log.size(), 2);
    if (rd_log.size() == 2 && st_log.size() == 2) begin
      check("t1_rd_latency",    rd_log[0] - push_cyc, 1);
      check("t1_start_latency", st_log[0] - rd_log[0], 2);
      check("t1_spacing",       rd_log[1] - rd_log[0], 19);
      check("t1_byte0",         data_log[0], 8'hA5);
      check("t1_byte1",         data_log[1], 8'h3C);
    end
    check("t1_count", byte_count, 2);
    check("t1_err",   tx_err, 0);

    // gap of 4 after each completed byte
    clear_logs();
    b0 = DW'($urandom); b1 = DW'($urandom); b2 = DW'($urandom);
    plan_a = {1, 1, 1}; plan_l = {3, 3, 3};
    push_q = {b0, b1, b2};
    run(60);
    check("t2_pops", rd_log.size(), 3);
    if (rd_log.size() == 3 && data_log.size() == 3) begin
      check("t2_spacing01", rd_log[1] - rd_log[0], 13);
      check("t2_spacing12", rd_log[2] - rd_log[1], 13);
      check("t2_byte2",     data_log[2], b2);
    end
    check("t2_count", byte_count, 5);

    // transmitter never acknowledges the first byte
    clear_logs();
    plan_a = {NEVER, 0}; plan_l = {1, 2};
    push_q = {8'h5A, 8'hC3};
    run(50);
    check("t3_pops", rd_log.size(), 2);
    if (rd_log.size() == 2) begin
      check("t3_err_time",   err_rise - rd_log[0], 18);
      check("t3_next_pop",   rd_log[1] - rd_log[0], 19);
    end
    check("t3_err",   tx_err, 1);
    check("t3_count", byte_count, 6);

    // enable dropped while the first byte is in DONE
    clear_logs();
    plan_a = {0, 0}; plan_l = {10, 10};
    push_q = {8'h01, 8'h02};
    step_until_rd(1, 10, "t4_first_pop");
    run(5);
    en_knob = 0;
    run(40);
    check("t4_pops_held", rd_log.size(), 1);
    check("t4_count",     byte_count, 7);
    en_knob = 1;
    step_until_rd(2, 4, "t4_resume_pop");
    run(30);
    check("t4_count_final", byte_count, 8);

    // reset pulsed during DONE
    clear_logs();
    plan_a = {0, 0}; plan_l = {10, 2};
    push_q = {8'hEE, 8'h77};
    step_until_rd(1, 10, "t5_first_pop");
    run(6);
    rst_req = 1;
    step();
    #1;
    check("t5_rst_rd_en",  fifo_rd_en, 0);
    check("t5_rst_start",  tx_start, 0);
    check("t5_rst_data",   tx_data, 0);
    check("t5_rst_busy",   sched_busy, 0);
    check("t5_rst_count",  byte_count, 0);
    check("t5_rst_err",    tx_err, 0);
    run(40);
    check("t5_pops",  rd_log.size(), 2);
    check("t5_count", byte_count, 1);

`ifdef UART_TX_SCHED_CTS_EN
    // CTS held off, then released
    cts_knob = 1;
    run(3);
    clear_logs();
    plan_a = {0}; plan_l = {2};
    push_q = {8'h99};
    run(50);
    check("t6_cts_hold", rd_log.size(), 0);
    cts_knob = 0;
    step_until_rd(1, 4, "t6_cts_release");
    run(30);
`endif

    // random traffic, random enable, occasional reset
    rand_push = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) en_knob = !en_knob;
      if ($urandom_range(0, 999) == 0) rst_req = 1;
      step();
    end
    rand_push = 0;
    en_knob   = 1;
    run(400);
    check("drained", fifo_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
